// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;
    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;
endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: lone requester wins, contention goes to the one not granted last.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [NREQ-1:0] valid,
    input  logic            last_grant,
    output logic [NREQ-1:0] grant
);
    always_comb begin
        grant = '0;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two command ports onto one single-port memory, one command every three cycles.
// Accept in IDLE, memory access in ISSUE, response pulse to the owner in RESP.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [WIDTH-1:0]  req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [WIDTH-1:0]  req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [WIDTH-1:0]  rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [WIDTH-1:0]  rsp1_rdata,
    output logic              rsp1_err,
    output logic              mem_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_write_data,
    input  logic [WIDTH-1:0]  mem_read_data
);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic              last_grant;
    logic              cap_owner;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [WIDTH-1:0]  cap_wdata;
    logic [NREQ-1:0]   grant;
    logic              accept;
    logic              in_range;
    logic              issue_go;
    logic              rsp_go;
    logic [WIDTH-1:0]  rsp_data;

    mem_arb_rr u_rr (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Outputs are gated by rst so an in-flight command is cut off in the reset cycle itself.
    assign req0_ready = !rst && (state == IDLE) && grant[0];
    assign req1_ready = !rst && (state == IDLE) && grant[1];
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign in_range   = {1'b0, cap_addr} < DEPTH_EXT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cap_owner  <= 1'b0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= ISSUE;
                        last_grant <= grant[1];
                        cap_owner  <= grant[1];
                        cap_write  <= grant[1] ? req1_write : req0_write;
                        cap_addr   <= grant[1] ? req1_addr  : req0_addr;
                        cap_wdata  <= grant[1] ? req1_wdata : req0_wdata;
                    end
                end
                ISSUE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign issue_go = !rst && (state == ISSUE) && in_range;
    assign rsp_go   = !rst && (state == RESP);
    assign rsp_data = (in_range && !cap_write) ? mem_read_data : '0;

    always_comb begin
        mem_en         = issue_go;
        mem_write      = issue_go && cap_write;
        mem_addr       = issue_go ? cap_addr  : '0;
        mem_write_data = issue_go ? cap_wdata : '0;

        rsp0_valid = rsp_go && !cap_owner;
        rsp1_valid = rsp_go &&  cap_owner;
        rsp0_rdata = rsp0_valid ? rsp_data : '0;
        rsp1_rdata = rsp1_valid ? rsp_data : '0;
        rsp0_err   = rsp0_valid && !in_range;
        rsp1_err   = rsp1_valid && !in_range;
    end
endmodule
